// File: rtl/sha3_row_bus_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : i_sha3_1600_row_bus
// Brief    : Keccak-f[1600] state row bus; 5 rows of 5 x 64-bit lanes plus sample.
// Revision : 1.0
// ============================================================================
interface i_sha3_1600_row_bus;
    logic        sample;
    logic [63:0] rowa [5];
    logic [63:0] rowb [5];
    logic [63:0] rowc [5];
    logic [63:0] rowd [5];
    logic [63:0] rowe [5];

    modport core   (output sample, rowa, rowb, rowc, rowd, rowe);
    modport periph (input  sample, rowa, rowb, rowc, rowd, rowe);
endinterface
`default_nettype wire

// File: rtl/sha3_row_bus_serializer.sv
`default_nettype none
// ============================================================================
// Module   : sha3_row_bus_serializer
// Brief    : Captures a 1600-bit state from the row bus and streams its first
//            OUT_LANES lanes as 64-bit words over a valid/ready interface.
// Revision : 1.0
// ============================================================================
module sha3_row_bus_serializer #(
    parameter int OUT_LANES = 25
) (
    input  logic                clk,
    input  logic                rst,
    i_sha3_1600_row_bus.periph  rows,
    output logic [63:0]         dout,
    output logic                dout_valid,
    input  logic                dout_ready,
    output logic                dout_last,
    output logic                busy,
    output logic                overrun
);

    localparam logic [0:0] c_st_idle   = 1'b0;
    localparam logic [0:0] c_st_drain  = 1'b1;
    localparam logic [4:0] c_last_lane = 5'(OUT_LANES - 1);

    logic [0:0]  r_state;
    logic [0:0]  w_state_nxt;
    logic [4:0]  r_cnt;
    logic [4:0]  w_cnt_nxt;
    logic        r_overrun;
    logic        w_overrun_nxt;
    logic        w_capture;
    logic        w_xfer;
    logic        w_last_xfer;
    logic [63:0] r_buf   [25];
    logic [63:0] w_lanes [25];

    // Lane L = x + 5*y, rows a..e carry y = 0..4.
    for (genvar gx = 0; gx < 5; gx++) begin : g_lane
        assign w_lanes[gx]      = rows.rowa[gx];
        assign w_lanes[gx + 5]  = rows.rowb[gx];
        assign w_lanes[gx + 10] = rows.rowc[gx];
        assign w_lanes[gx + 15] = rows.rowd[gx];
        assign w_lanes[gx + 20] = rows.rowe[gx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_cnt     <= 5'd0;
            r_overrun <= 1'b0;
            for (int i = 0; i < 25; i++) begin
                r_buf[i] <= 64'd0;
            end
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_overrun <= w_overrun_nxt;
            if (w_capture) begin
                for (int i = 0; i < 25; i++) begin
                    r_buf[i] <= w_lanes[i];
                end
            end
        end
    end

    assign w_xfer      = (r_state == c_st_drain) && dout_ready;
    assign w_last_xfer = w_xfer && (r_cnt == c_last_lane);

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_capture     = 1'b0;
        w_overrun_nxt = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (rows.sample) begin
                    w_capture   = 1'b1;
                    w_cnt_nxt   = 5'd0;
                    w_state_nxt = c_st_drain;
                end
            end
            c_st_drain: begin
                if (w_last_xfer) begin
                    // A sample coinciding with the final transfer starts the next stream without a bubble.
                    w_cnt_nxt = 5'd0;
                    if (rows.sample) begin
                        w_capture = 1'b1;
                    end else begin
                        w_state_nxt = c_st_idle;
                    end
                end else begin
                    if (w_xfer) begin
                        w_cnt_nxt = r_cnt + 5'd1;
                    end
                    if (rows.sample) begin
                        w_overrun_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
                w_cnt_nxt   = 5'd0;
            end
        endcase
    end

    always_comb begin
        dout       = 64'd0;
        dout_valid = 1'b0;
        dout_last  = 1'b0;
        busy       = 1'b0;
        overrun    = r_overrun;
        if (r_state == c_st_drain) begin
            dout       = r_buf[r_cnt];
            dout_valid = 1'b1;
            dout_last  = (r_cnt == c_last_lane);
            busy       = 1'b1;
        end
    end

endmodule
`default_nettype wire
